// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider FSM states and the
// quotient returned for a divide by zero.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left by one, then do a trial
// subtract of the divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  // The bit shifted out of R is kept as r_sh[WIDTH], so divisors above
  // 2^(WIDTH-1) still divide correctly; diff[WIDTH] is then exactly the borrow.
  always_comb begin
    r_sh = {r_i, q_i[WIDTH-1]};
    diff = r_sh - {1'b0, divisor_i};
    if (!diff[WIDTH]) begin
      r_o = diff[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      r_o = r_sh[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when dividend < divisor.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] step_r, step_q;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    accept  = start && (state_q != RUN);

    if (accept) begin
      dvs_d = divisor;
      dbz_d = 1'b0;
      cnt_d = '0;
      if (divisor == '0) begin
        state_d = DONE;
        q_d     = '1;
        r_d     = dividend;
        dbz_d   = 1'b1;
`ifdef DIV_EARLY_OUT_EN
      end else if (dividend < divisor) begin
        state_d = DONE;
        q_d     = '0;
        r_d     = dividend;
`endif
      end else begin
        state_d = RUN;
        q_d     = dividend;
        r_d     = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed self-checking bench for alu_div_seq with hand-computed results.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif

  alu_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge (E0) and return #1 after it.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 after E0; lat counts edges from E0 (inclusive) to done.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    lat++;
  endtask

  task automatic check_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                              input logic edz);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"},  remainder, er);
    check({tag, "_dbz"},  32'(div_by_zero), 32'(edz));
  endtask

  task automatic full_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int elat);
    int lat, bc;
    start_div(a, b);
    wait_done(lat, bc);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check_result(tag, eq, er, edz);
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bc;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk) rst = 1'b0;

    // 555/246 with busy-length check
    start_div(32'd555, 32'd246);
    wait_done(lat, bc);
    check("b_lat", 32'(lat), 32'd33);
    check("b_busy_cycles", 32'(bc), 32'd32);
    check_result("b", 32'd2, 32'd63, 1'b0);
    @(posedge clk);
    #1 check("b_done_pulse", 32'(done), 32'd0);

    full_div("max2", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 33);
    full_div("max1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    full_div("dz", 32'd12345678, 32'd0, 32'hFFFF_FFFF, 32'd12345678, 1'b1, 1);
    full_div("small", 32'd6, 32'd9, 32'd0, 32'd6, 1'b0, SMALL_LAT);
    full_div("bigdiv", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33);
    full_div("dzclr", 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 33);

    // start while busy is ignored; start held in DONE is accepted back-to-back
    start_div(32'd555, 32'd246);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk) start = 1'b0;
    dividend = 32'd555; divisor = 32'd246;
    #1;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_result("ign", 32'd2, 32'd63, 1'b0);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat, bc);
    check("b2b_lat", 32'(lat), 32'd33);
    check_result("b2b", 32'd14, 32'd2, 1'b0);

    // reset at RUN cycle 10 aborts
    start_div(32'd555, 32'd246);
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quot", quotient, 32'd0);
    check("abort_rem", remainder, 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    bc = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) bc++;
    end
    check("abort_idle", 32'(bc), 32'd0);
    full_div("zero", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, SMALL_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
